// File: rtl/simon_host_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_host_bridge_if
// Brief    : Host byte streams plus SIMON core key/data handshake bundle.
// Revision : 1.0
// ============================================================================
interface simon_host_bridge_if #(
    parameter int N = 48,
    parameter int M = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_byte;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_byte;
    logic                newKey;
    logic [M-1:0][N-1:0] KEY;
    logic                loadKey;
    logic                doneKey;
    logic                newData;
    logic                enc_dec;
    logic [1:0][N-1:0]   blockOUT;
    logic                loadData;
    logic                doneData;
    logic [1:0][N-1:0]   resData;
    logic                readData;
    logic                key_ok;
    logic                busy;
    logic                err;

    // master: the bridge itself; slave: host shim plus cipher core
    modport master (
        input  in_valid, in_byte, out_ready, loadKey, doneKey, loadData, doneData, resData,
        output in_ready, out_valid, out_byte, newKey, KEY, newData, enc_dec, blockOUT,
               readData, key_ok, busy, err
    );

    modport slave (
        output in_valid, in_byte, out_ready, loadKey, doneKey, loadData, doneData, resData,
        input  in_ready, out_valid, out_byte, newKey, KEY, newData, enc_dec, blockOUT,
               readData, key_ok, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/simon_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : simon_host_bridge
// Brief    : Byte-serial command front end driving the SIMON 96/96 core.
// Revision : 1.0
// ============================================================================
module simon_host_bridge #(
    parameter int N = 48,
    parameter int M = 2
) (
    input  wire logic            clk,
    input  wire logic            R,
    simon_host_bridge_if.master  bus
);
    localparam int c_KEY_W     = M * N;
    localparam int c_BLK_W     = 2 * N;
    localparam int c_SR_W      = (c_KEY_W > c_BLK_W) ? c_KEY_W : c_BLK_W;
    localparam int c_KEY_BYTES = c_KEY_W / 8;
    localparam int c_BLK_BYTES = c_BLK_W / 8;
    localparam int c_MAX_BYTES = (c_KEY_BYTES > c_BLK_BYTES) ? c_KEY_BYTES : c_BLK_BYTES;
    localparam int c_CNT_W     = $clog2(c_MAX_BYTES);

    localparam logic [3:0] c_ST_CMD      = 4'd0;
    localparam logic [3:0] c_ST_RX_KEY   = 4'd1;
    localparam logic [3:0] c_ST_RX_BLK   = 4'd2;
    localparam logic [3:0] c_ST_DROP     = 4'd3;
    localparam logic [3:0] c_ST_KEY_REQ  = 4'd4;
    localparam logic [3:0] c_ST_KEY_WAIT = 4'd5;
    localparam logic [3:0] c_ST_DAT_REQ  = 4'd6;
    localparam logic [3:0] c_ST_DAT_WAIT = 4'd7;
    localparam logic [3:0] c_ST_ACK      = 4'd8;
    localparam logic [3:0] c_ST_TX       = 4'd9;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_SR_W-1:0]  r_sr;
    logic [c_SR_W-1:0]  w_sr_nxt;
    logic [c_KEY_W-1:0] r_key;
    logic [c_BLK_W-1:0] r_blk;
    logic [c_BLK_W-1:0] r_res;
    logic               r_enc;
    logic               r_key_ok;
    logic               r_err;

    logic w_in_ready;
    logic w_out_valid;
    logic w_new_key;
    logic w_new_data;
    logic w_read_data;
    logic w_in_fire;
    logic w_out_fire;
    logic w_key_last;
    logic w_blk_last;
    logic w_rx_last;
    logic w_cmd_blk;

    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && bus.out_ready;
    assign w_key_last = (r_cnt == c_CNT_W'(c_KEY_BYTES - 1));
    assign w_blk_last = (r_cnt == c_CNT_W'(c_BLK_BYTES - 1));
    assign w_rx_last  = (r_state == c_ST_RX_KEY) ? w_key_last : w_blk_last;
    assign w_cmd_blk  = (bus.in_byte == 8'h02) || (bus.in_byte == 8'h03);
    // First payload byte ends up in the most significant byte
    assign w_sr_nxt   = {r_sr[c_SR_W-9:0], bus.in_byte};

    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= c_ST_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CMD: begin
                if (w_in_fire) begin
                    if (bus.in_byte == 8'h01) begin
                        w_state_nxt = c_ST_RX_KEY;
                    end else if (w_cmd_blk) begin
                        w_state_nxt = r_key_ok ? c_ST_RX_BLK : c_ST_DROP;
                    end
                end
            end
            c_ST_RX_KEY:   if (w_in_fire && w_key_last) w_state_nxt = c_ST_KEY_REQ;
            c_ST_RX_BLK:   if (w_in_fire && w_blk_last) w_state_nxt = c_ST_DAT_REQ;
            c_ST_DROP:     if (w_in_fire && w_blk_last) w_state_nxt = c_ST_CMD;
            c_ST_KEY_REQ:  if (bus.loadKey)  w_state_nxt = c_ST_KEY_WAIT;
            c_ST_KEY_WAIT: if (bus.doneKey)  w_state_nxt = c_ST_CMD;
            c_ST_DAT_REQ:  if (bus.loadData) w_state_nxt = c_ST_DAT_WAIT;
            c_ST_DAT_WAIT: if (bus.doneData) w_state_nxt = c_ST_ACK;
            c_ST_ACK:      w_state_nxt = c_ST_TX;
            c_ST_TX:       if (w_out_fire && w_blk_last) w_state_nxt = c_ST_CMD;
            default:       w_state_nxt = c_ST_CMD;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_new_key   = 1'b0;
        w_new_data  = 1'b0;
        w_read_data = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_ST_CMD, c_ST_RX_KEY, c_ST_RX_BLK, c_ST_DROP: w_in_ready = !R;
            c_ST_KEY_REQ: w_new_key   = 1'b1;
            c_ST_DAT_REQ: w_new_data  = 1'b1;
            c_ST_ACK:     w_read_data = 1'b1;
            c_ST_TX:      w_out_valid = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (R) begin
            r_cnt    <= '0;
            r_sr     <= '0;
            r_key    <= '0;
            r_blk    <= '0;
            r_res    <= '0;
            r_enc    <= 1'b0;
            r_key_ok <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CMD: begin
                    r_cnt <= '0;
                    if (w_in_fire && bus.in_byte != 8'h01) begin
                        if (w_cmd_blk && r_key_ok) begin
                            r_enc <= (bus.in_byte == 8'h02);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_RX_KEY, c_ST_RX_BLK, c_ST_DROP: begin
                    if (w_in_fire) begin
                        r_sr  <= w_sr_nxt;
                        r_cnt <= w_rx_last ? '0 : r_cnt + 1'b1;
                        if (r_state == c_ST_RX_KEY && w_key_last) begin
                            r_key    <= w_sr_nxt[c_KEY_W-1:0];
                            r_key_ok <= 1'b0;
                        end
                        if (r_state == c_ST_RX_BLK && w_blk_last) begin
                            r_blk <= w_sr_nxt[c_BLK_W-1:0];
                        end
                    end
                end
                c_ST_KEY_WAIT: if (bus.doneKey) r_key_ok <= 1'b1;
                c_ST_DAT_WAIT: if (bus.doneData) r_res <= bus.resData;
                c_ST_ACK:      r_cnt <= '0;
                c_ST_TX: begin
                    if (w_out_fire) begin
                        r_res <= {r_res[c_BLK_W-9:0], 8'h00};
                        r_cnt <= w_blk_last ? '0 : r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_byte  = w_out_valid ? r_res[c_BLK_W-1 -: 8] : 8'h00;
    assign bus.newKey    = w_new_key;
    assign bus.KEY       = r_key;
    assign bus.newData   = w_new_data;
    assign bus.enc_dec   = r_enc;
    assign bus.blockOUT  = r_blk;
    assign bus.readData  = w_read_data;
    assign bus.key_ok    = r_key_ok;
    assign bus.busy      = (r_state != c_ST_CMD);
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_simon_host_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_host_bridge
// Brief    : Self-checking bench; plays host shim and cipher core.
// Revision : 1.0
// ============================================================================
module tb_simon_host_bridge;
    localparam int N = 48;
    localparam int M = 2;

    localparam logic [95:0] c_KEY = 96'h0d0c0b0a0908_050403020100;
    localparam logic [95:0] c_PT  = 96'h2072616c6c69_702065687420;
    localparam logic [95:0] c_CT  = 96'h602807a462b4_69063d8ff082;

    logic clk = 1'b0;
    logic R   = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   nd_cycles = 0;
    int   rd_cycles = 0;

    always #5 clk = ~clk;

    simon_host_bridge_if #(.N(N), .M(M)) bus ();
    simon_host_bridge #(.N(N), .M(M)) dut (.clk(clk), .R(R), .bus(bus));

    always @(posedge clk) begin
        if (bus.newData === 1'b1)  nd_cycles <= nd_cycles + 1;
        if (bus.readData === 1'b1) rd_cycles <= rd_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        bus.loadKey   = 1'b0;
        bus.doneKey   = 1'b0;
        bus.loadData  = 1'b0;
        bus.doneData  = 1'b0;
        bus.resData   = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit first, output bit ok);
        logic rdy;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        ok    = 1'b0;
        first = (bus.in_ready === 1'b1);
        for (int k = 0; k < 20; k++) begin
            rdy = bus.in_ready;
            tick();
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Command byte then 12 payload bytes, most significant byte first
    task automatic send_frame(input logic [7:0] cmd, input logic [95:0] pl, input bit gaps,
                              output int n_first);
        bit first, ok;
        logic [7:0] b;
        n_first = 0;
        for (int i = 0; i < 13; i++) begin
            b = (i == 0) ? cmd : pl[95 - 8*(i-1) -: 8];
            if (gaps) repeat ($urandom_range(0, 1)) tick();
            send_byte(b, first, ok);
            if (first && ok) n_first++;
        end
    endtask

    task automatic load_key(input logic [95:0] key, input bit gaps, output int n_first,
                            output int lat, output logic [95:0] key_seen, output logic kok_req,
                            output logic rdy_req, output logic nk_after, output logic kok_after,
                            output logic busy_after);
        send_frame(8'h01, key, gaps, n_first);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.newKey === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        key_seen = bus.KEY;
        kok_req  = bus.key_ok;
        rdy_req  = bus.in_ready;
        bus.loadKey = 1'b1;
        tick();
        bus.loadKey = 1'b0;
        nk_after = bus.newKey;
        repeat ($urandom_range(1, 3)) tick();
        bus.doneKey = 1'b1;
        tick();
        bus.doneKey = 1'b0;
        kok_after  = bus.key_ok;
        busy_after = bus.busy;
    endtask

    // Acts as the core: returns res for the block, then drains the 12 output bytes
    task automatic run_block(input logic [7:0] cmd, input logic [95:0] blk, input logic [95:0] res,
                             input int bp_at, input bit rnd, input bit gaps,
                             output int lat, output logic [95:0] blk_seen, output logic enc_seen,
                             output logic nd_after, output logic rd1, output logic rd0,
                             output logic [95:0] got, output int n, output bit stable,
                             output logic ov_after, output logic busy_after);
        int   n_first;
        int   low;
        logic rdy;
        logic prev_hold;
        logic [7:0] prev_byte;
        send_frame(cmd, blk, gaps, n_first);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.newData === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        blk_seen = bus.blockOUT;
        enc_seen = bus.enc_dec;
        bus.loadData = 1'b1;
        tick();
        bus.loadData = 1'b0;
        nd_after = bus.newData;
        repeat ($urandom_range(1, 3)) tick();
        bus.doneData = 1'b1;
        bus.resData  = res;
        tick();
        rd1 = bus.readData;
        bus.doneData = 1'b0;
        bus.resData  = {$urandom, $urandom, $urandom};
        tick();
        rd0 = bus.readData;
        got = '0;
        n = 0;
        low = 0;
        stable = 1'b1;
        prev_hold = 1'b0;
        prev_byte = 8'h00;
        for (int cyc = 0; cyc < 200 && n < 12; cyc++) begin
            if (bp_at >= 0 && n == bp_at && low < 5) begin
                rdy = 1'b0;
                low++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 1) == 1);
            end else begin
                rdy = 1'b1;
            end
            bus.out_ready = rdy;
            if (prev_hold && bus.out_byte !== prev_byte) stable = 1'b0;
            if (bus.out_valid === 1'b1 && rdy) begin
                got = {got[87:0], bus.out_byte};
                n++;
            end
            prev_hold = (bus.out_valid === 1'b1) && !rdy;
            prev_byte = bus.out_byte;
            tick();
        end
        bus.out_ready = 1'b0;
        ov_after   = bus.out_valid;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        idle_inputs();
        R = 1'b1;
        tick();
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready_during_R: got %b want 0", bus.in_ready);
        end
        tick();
        R = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready_after: got %b want 1", bus.in_ready);
        end
        total++;
        if ({bus.out_valid, bus.newKey, bus.newData, bus.readData, bus.enc_dec,
             bus.key_ok, bus.busy, bus.err} !== 8'h00) begin
            bad++;
            $display("FAIL reset_flags: got ov,nk,nd,rd,ed,kok,busy,err=%b want 00000000",
                     {bus.out_valid, bus.newKey, bus.newData, bus.readData, bus.enc_dec,
                      bus.key_ok, bus.busy, bus.err});
        end
        total++;
        if ({bus.KEY, bus.blockOUT, bus.out_byte} !== '0) begin
            bad++;
            $display("FAIL reset_data: got KEY=%h blk=%h ob=%h want all zero",
                     bus.KEY, bus.blockOUT, bus.out_byte);
        end
    endtask

    task automatic test_no_key();
        int   n_first;
        int   nd0;
        bit   first, ok;
        nd0 = nd_cycles;
        send_frame(8'h02, {$urandom, $urandom, $urandom}, 1'b0, n_first);
        repeat (5) tick();
        total++;
        if (n_first !== 13) begin
            bad++;
            $display("FAIL nokey_in_ready: got %0d bytes on first try want 13", n_first);
        end
        total++;
        if (bus.err !== 1'b1) begin
            bad++;
            $display("FAIL nokey_err: got %b want 1", bus.err);
        end
        total++;
        if (nd_cycles - nd0 !== 0) begin
            bad++;
            $display("FAIL nokey_newData: got %0d cycles want 0", nd_cycles - nd0);
        end
        send_byte(8'h7F, first, ok);
        tick();
        total++;
        if ({ok, bus.err, bus.busy, bus.key_ok} !== 4'b1100) begin
            bad++;
            $display("FAIL badcmd: got ok,err,busy,kok=%b want 1100",
                     {ok, bus.err, bus.busy, bus.key_ok});
        end
    endtask

    task automatic test_key_load();
        int   n_first, lat;
        logic [95:0] key_seen;
        logic kok_req, rdy_req, nk_after, kok_after, busy_after;
        load_key(c_KEY, 1'b0, n_first, lat, key_seen, kok_req, rdy_req, nk_after, kok_after, busy_after);
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL key_newKey_latency: got %0d want 0", lat);
        end
        total++;
        if (key_seen !== c_KEY) begin
            bad++;
            $display("FAIL key_value: got %h want %h", key_seen, c_KEY);
        end
        total++;
        if ({kok_req, rdy_req, nk_after} !== 3'b000) begin
            bad++;
            $display("FAIL key_req_flags: got kok,in_ready,newKey_after=%b want 000",
                     {kok_req, rdy_req, nk_after});
        end
        total++;
        if ({kok_after, busy_after} !== 2'b10) begin
            bad++;
            $display("FAIL key_done: got key_ok,busy=%b want 10", {kok_after, busy_after});
        end
    endtask

    task automatic check_block(input string name, input logic [7:0] cmd, input logic [95:0] blk,
                               input logic [95:0] res, input int bp_at, input bit rnd, input bit gaps);
        int   lat, n, rd_before;
        logic [95:0] blk_seen, got;
        logic enc_seen, nd_after, rd1, rd0, ov_after, busy_after;
        bit   stable;
        rd_before = rd_cycles;
        run_block(cmd, blk, res, bp_at, rnd, gaps, lat, blk_seen, enc_seen, nd_after, rd1, rd0,
                  got, n, stable, ov_after, busy_after);
        total++;
        if (lat !== 0 || nd_after !== 1'b0) begin
            bad++;
            $display("FAIL %s newData: got latency=%0d after_load=%b want 0,0", name, lat, nd_after);
        end
        total++;
        if ({blk_seen, enc_seen} !== {blk, cmd == 8'h02}) begin
            bad++;
            $display("FAIL %s block: got %h enc=%b want %h enc=%b", name, blk_seen, enc_seen,
                     blk, cmd == 8'h02);
        end
        total++;
        if ({rd1, rd0} !== 2'b10 || rd_cycles - rd_before !== 1) begin
            bad++;
            $display("FAIL %s readData: got pattern=%b pulses=%0d want 10,1", name, {rd1, rd0},
                     rd_cycles - rd_before);
        end
        total++;
        if (n !== 12 || got !== res) begin
            bad++;
            $display("FAIL %s out_bytes: got n=%0d %h want n=12 %h", name, n, got, res);
        end
        total++;
        if (!stable || ov_after !== 1'b0 || busy_after !== 1'b0) begin
            bad++;
            $display("FAIL %s out_end: got stable=%b out_valid=%b busy=%b want 1,0,0", name,
                     stable, ov_after, busy_after);
        end
    endtask

    task automatic test_encrypt();
        check_block("encrypt", 8'h02, c_PT, c_CT, -1, 1'b0, 1'b0);
    endtask

    task automatic test_decrypt();
        check_block("decrypt", 8'h03, c_CT, c_PT, -1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        check_block("backpressure", 8'h02, c_PT, c_CT, 5, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        bit   first, ok;
        int   n_first, lat;
        logic [95:0] key, key_seen;
        logic kok_req, rdy_req, nk_after, kok_after, busy_after;
        send_byte(8'h01, first, ok);
        for (int i = 0; i < 6; i++) send_byte(c_KEY[95 - 8*i -: 8], first, ok);
        R = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        R = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.busy, bus.key_ok, bus.newKey, bus.err, bus.enc_dec} !== 6'b100000 ||
            {bus.KEY, bus.blockOUT} !== '0) begin
            bad++;
            $display("FAIL midreset_state: got rdy,busy,kok,nk,err,ed=%b KEY=%h blk=%h want 100000,0,0",
                     {bus.in_ready, bus.busy, bus.key_ok, bus.newKey, bus.err, bus.enc_dec},
                     bus.KEY, bus.blockOUT);
        end
        key = {$urandom, $urandom, $urandom};
        load_key(key, 1'b0, n_first, lat, key_seen, kok_req, rdy_req, nk_after, kok_after, busy_after);
        total++;
        if (n_first !== 13 || lat !== 0 || key_seen !== key || kok_after !== 1'b1) begin
            bad++;
            $display("FAIL midreset_reload: got n=%0d lat=%0d key=%h kok=%b want 13,0,%h,1",
                     n_first, lat, key_seen, kok_after, key);
        end
    endtask

    task automatic test_random();
        int   n_first, lat;
        logic [95:0] key, key_seen, blk, res;
        logic [7:0]  cmd;
        logic kok_req, rdy_req, nk_after, kok_after, busy_after;
        for (int it = 0; it < 6; it++) begin
            if (it % 3 == 0) begin
                key = {$urandom, $urandom, $urandom};
                load_key(key, 1'b1, n_first, lat, key_seen, kok_req, rdy_req, nk_after,
                         kok_after, busy_after);
                total++;
                if (key_seen !== key || kok_after !== 1'b1) begin
                    bad++;
                    $display("FAIL random_key: got %h kok=%b want %h kok=1", key_seen, kok_after, key);
                end
            end
            cmd = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h03;
            blk = {$urandom, $urandom, $urandom};
            res = {$urandom, $urandom, $urandom};
            check_block("random", cmd, blk, res, -1, 1'b1, 1'b1);
        end
        total++;
        if (bus.err !== 1'b0) begin
            bad++;
            $display("FAIL random_err: got %b want 0", bus.err);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_no_key();
        test_reset();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/simon_host_bridge.md
# simon_host_bridge

Byte-serial host front end for the SIMON 96/96 cipher core: the initiator side of the core's key/data handshake. It accepts command frames on an 8-bit valid/ready stream and assembles 96-bit keys and blocks. It drives the core's newKey/loadKey/doneKey and newData/loadData/doneData/readData handshakes, then returns each result block as 12 bytes on an 8-bit valid/ready output stream. It sits between the system byte bus (UART/SPI shim) and the cipher core.

## Interface
- N, 48, cipher word width in bits; 2N and M*N must be multiples of 8.
- M, 2, key words.
- clk  in  1  clock; all state changes on rising edge
- R  in  1  synchronous active-high reset
- in_valid / in_ready  in / out  1 / 1  host byte stream handshake
- in_byte  in  8  host byte
- out_valid / out_ready  out / in  1 / 1  result byte stream handshake
- out_byte  out  8  result byte
- newKey  out  1  key request to core; held until loadKey
- KEY  out  [M-1:0][N-1:0]  key to core; stable while newKey high
- loadKey  in  1  core captured key (1-cycle pulse)
- doneKey  in  1  core key schedule ready
- newData  out  1  block request to core; held until loadData
- enc_dec  out  1  1 = encrypt, 0 = decrypt; stable while newData high
- blockOUT  out  [1:0][N-1:0]  block to core
- loadData  in  1  core captured block (1-cycle pulse)
- doneData  in  1  result valid on resData; held until readData
- resData  in  [1:0][N-1:0]  core result
- readData  out  1  1-cycle acknowledge of result
- key_ok  out  1  a key has been loaded and doneKey seen since reset
- busy  out  1  state is not CMD
- err  out  1  sticky protocol error; cleared only by R

## Operation
- Frame: 1 command byte, then 12 payload bytes, MSB first. Byte 0 maps to bits [2N-1:2N-8] of {word1,word0}.
- Commands: 0x01 load key; 0x02 encrypt; 0x03 decrypt. Any other byte sets err, is consumed, and the block stays in CMD.
- 0x02/0x03 with key_ok=0: set err, consume and discard 12 payload bytes (state DROP), no core activity.
- States: CMD, RX_KEY, RX_BLK, DROP, KEY_REQ, KEY_WAIT, DAT_REQ, DAT_WAIT, ACK, TX.
- CMD → RX_KEY / RX_BLK / DROP on an accepted command byte.
- RX_* / DROP: 4-bit byte counter 0..11, shifting each byte into a 96-bit shift register. At count 11 accepted: RX_KEY→KEY_REQ, RX_BLK→DAT_REQ, DROP→CMD.
- KEY_REQ: newKey=1 until loadKey sampled, then →KEY_WAIT. On doneKey: key_ok=1, →CMD.
- DAT_REQ: newData=1 until loadData, then →DAT_WAIT. On doneData: capture resData, →ACK.
- ACK: readData=1 for exactly one cycle, →TX.
- TX: 12 bytes from the captured result, MSB first. Counter advances only on out_valid&&out_ready. After the last byte →CMD.
- Loading a new key clears key_ok on entry to KEY_REQ.
- KEY/blockOUT/enc_dec are registered and change only in RX_*/CMD.

## Timing
- Reset values: in_ready=0 during R, then 1 in CMD; out_valid=0, out_byte=0, newKey=0, newData=0, readData=0, KEY=0, blockOUT=0, enc_dec=0, key_ok=0, busy=0, err=0.
- R asserted in any state → CMD next cycle, with all of the above values, counters cleared.
- in_ready=1 only in CMD, RX_KEY, RX_BLK, DROP; a byte transfers on in_valid&&in_ready.
- newKey/newData rise the cycle after the last payload byte. A loadKey/loadData pulse in the same cycle as the request edge is honoured.
- readData rises the cycle after doneData is sampled.
- out_valid rises the cycle after readData. out_byte holds steady while out_valid&&!out_ready.
- Throughput: max one byte per cycle each direction; frame overhead 1 cycle command + 12 payload + 2 handshake cycles plus core latency.

## Test plan
- Bytes 0x01,0d 0c 0b 0a 09 08 05 04 03 02 01 00 → newKey with KEY[1]=0x0d0c0b0a0908, KEY[0]=0x050403020100. Drop after loadKey; key_ok=1 after doneKey.
- After key load, 0x02 + bytes of 0x2072616c6c69_702065687420 → enc_dec=1, core model returns 0x602807a462b4_69063d8ff082 → one readData pulse, out bytes 60 28 07 … f0 82.
- 0x03 with ciphertext payload → enc_dec=0; output bytes equal the plaintext above.
- From reset, 0x02 + 12 bytes → err=1, newData never asserted, in_ready high for all 13 bytes. Then 0x7F → err stays 1, busy=0.
- Output backpressure: out_ready low 5 cycles mid-frame → out_byte stable, no byte lost or duplicated, 12 bytes total.
- R pulsed after 6 key payload bytes → all outputs at reset values. A fresh full key frame then completes normally.
